// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Line-oriented backing memory for a cache. It stores DEPTH_LINES lines of
//   128 bits and answers one request at a time. The answer comes back LATENCY
//   cycles after acceptance as a one-cycle MemReady pulse. The control FSM
//   walks IDLE -> WAIT -> RESP -> DONE -> IDLE.
//
// Parameters
//   LATENCY      cycles from acceptance to MemReady (1..15)
//   DEPTH_LINES  number of 128-bit lines (power of two, >= 2)
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   AMem       byte address of the line; the index is AMem[log2(DEPTH)+3:4]
//   MemRead    line-read request level, held until MemReady
//   MemWrite   line-write request level (only with DMEM_WRITE_EN)
//   WriteLine  line to store (only with DMEM_WRITE_EN)
//   MemLine    last line read; word k sits in bits [32k+31:32k]
//   MemReady   one-cycle completion pulse
//   MemBusy    high whenever the FSM is not IDLE
//
// Configuration macro
//   DMEM_WRITE_EN  adds MemWrite/WriteLine and the write path. Without it the
//                  block is read-only, and simulation preloads the array.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int LATENCY     = 5,
    parameter int DEPTH_LINES = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  AMem,
    input  logic         MemRead,
`ifdef DMEM_WRITE_EN
    input  logic         MemWrite,
    input  logic [127:0] WriteLine,
`endif
    output logic [127:0] MemLine,
    output logic         MemReady,
    output logic         MemBusy
);

    localparam int         IDX_W  = $clog2(DEPTH_LINES);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [127:0]       line_q, line_d;

    logic [127:0]       mem_q [DEPTH_LINES];

    logic               wr_req_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [IDX_W-1:0]   op_idx_s;
    logic               op_write_s;
    logic               enter_resp_s;
    logic               amem_unused_s;

    // The offset bits and the bits above the index do not select a line.
    assign amem_unused_s = ^{AMem[31:IDX_W+4], AMem[3:0]};

`ifdef DMEM_WRITE_EN
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       op_wdata_s;
    logic               mem_we_s;

    // A write wins when both requests are raised together.
    assign wr_req_s = MemWrite;
`else
    assign wr_req_s = 1'b0;
`endif

    // Next-state logic. The op_* signals carry the operation that reaches
    // RESP on this edge. With LATENCY=1 that is the request being accepted
    // right now, not the latched copy.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        write_d      = write_q;
        enter_resp_s = 1'b0;
        req_idx_s    = AMem[IDX_W+3:4];
        op_idx_s     = idx_q;
        op_write_s   = write_q;
        case (state_q)
            IDLE: begin
                if (MemRead || wr_req_s) begin
                    idx_d      = req_idx_s;
                    write_d    = wr_req_s;
                    op_idx_s   = req_idx_s;
                    op_write_s = wr_req_s;
                    if (LATENCY == 1) begin
                        state_d      = RESP;
                        cnt_d        = 4'd0;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Only reads update MemLine. Writes leave the last read line in place.
        if (enter_resp_s && !op_write_s) begin
            line_d = mem_q[op_idx_s];
        end else begin
            line_d = line_q;
        end

        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
    end

    // Control state, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= {IDX_W{1'b0}};
            write_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            line_q  <= {128{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            line_q  <= line_d;
        end
    end

`ifdef DMEM_WRITE_EN
    // Write data is captured at acceptance, so later changes on WriteLine
    // cannot reach the array.
    always_comb begin
        if (state_q == IDLE && (MemRead || MemWrite)) begin
            wdata_d    = WriteLine;
            op_wdata_s = WriteLine;
        end else begin
            wdata_d    = wdata_q;
            op_wdata_s = wdata_q;
        end
        mem_we_s = enter_resp_s && op_write_s;
    end

    // Latched write data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_q <= {128{1'b0}};
        end else begin
            wdata_q <= wdata_d;
        end
    end

    // Line array. Reset does not clear it. The write lands on the edge that
    // enters RESP.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[op_idx_s] <= op_wdata_s;
        end
    end
`endif

    assign MemLine  = line_q;
    assign MemReady = ready_q;
    assign MemBusy  = busy_q;

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//   Self-checking bench for data_memory. A line-array model and the
//   address-to-line rule (addr / 16 mod DEPTH) predict every response.
//   Addresses are random, and the request inputs are disturbed while a
//   request is in flight. Two instances are used: LATENCY=5 for the main
//   checks and LATENCY=1 for the back-to-back case.
// -----------------------------------------------------------------------------
module tb_data_memory;

    localparam int LAT   = 5;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  AMem;
    logic         MemRead;
    logic [127:0] MemLine;
    logic         MemReady;
    logic         MemBusy;
`ifdef DMEM_WRITE_EN
    logic         MemWrite;
    logic [127:0] WriteLine;
    logic         w1;
    logic [127:0] wl1;
`endif
    logic [31:0]  a1;
    logic         rd1;
    logic [127:0] line1;
    logic         ready1;
    logic         busy1;

    logic [127:0] model_mem [DEPTH];
    logic [127:0] last_line;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    data_memory #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .AMem     (AMem),
        .MemRead  (MemRead),
`ifdef DMEM_WRITE_EN
        .MemWrite (MemWrite),
        .WriteLine(WriteLine),
`endif
        .MemLine  (MemLine),
        .MemReady (MemReady),
        .MemBusy  (MemBusy)
    );

    data_memory #(.LATENCY(1), .DEPTH_LINES(DEPTH)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .AMem     (a1),
        .MemRead  (rd1),
`ifdef DMEM_WRITE_EN
        .MemWrite (w1),
        .WriteLine(wl1),
`endif
        .MemLine  (line1),
        .MemReady (ready1),
        .MemBusy  (busy1)
    );

    // Count one comparison and report it if the values differ.
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Line selected by a byte address: 16-byte lines, wrapping over DEPTH.
    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32'd16) % DEPTH);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full read handshake. AMem is switched to 'alt' while the request is in flight.
    task automatic read_txn(input string tag, input logic [31:0] addr, input logic [31:0] alt);
        int n;
        logic [127:0] exp;
        exp = model_mem[line_of(addr)];
        @(negedge clk);
        chk({tag, "_idle"}, 128'(MemBusy), 128'(1'b0));
        AMem    = addr;
        MemRead = 1'b1;
        @(negedge clk);
        chk({tag, "_busy"}, 128'(MemBusy), 128'(1'b1));
        AMem = alt;
        n = 0;
        while (!MemReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(LAT));
        chk({tag, "_data"}, MemLine, exp);
        MemRead   = 1'b0;
        AMem      = $urandom;
        last_line = exp;
        @(negedge clk);
        chk({tag, "_single"}, 128'(MemReady), 128'(1'b0));
        chk({tag, "_hold"}, MemLine, last_line);
        @(negedge clk);
        chk({tag, "_free"}, 128'(MemBusy), 128'(1'b0));
    endtask

`ifdef DMEM_WRITE_EN
    // Full write handshake, optionally with MemRead raised at the same time.
    task automatic write_txn(input string tag, input logic [31:0] addr,
                             input logic [127:0] data, input logic both);
        int n;
        int pulses;
        @(negedge clk);
        AMem      = addr;
        MemWrite  = 1'b1;
        MemRead   = both;
        WriteLine = data;
        @(negedge clk);
        AMem      = $urandom;
        WriteLine = ~data;
        n = 0;
        while (!MemReady && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(LAT));
        chk({tag, "_keep"}, MemLine, last_line);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        pulses   = 0;
        repeat (3) begin
            @(negedge clk);
            if (MemReady) pulses++;
        end
        chk({tag, "_pulses"}, 128'(pulses), 128'(0));
        model_mem[line_of(addr)] = data;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int prev;
        rst       = 1'b0;
        AMem      = 32'd0;
        MemRead   = 1'b0;
        a1        = 32'd0;
        rd1       = 1'b0;
        last_line = {128{1'b0}};
`ifdef DMEM_WRITE_EN
        MemWrite  = 1'b0;
        WriteLine = {128{1'b0}};
        w1        = 1'b0;
        wl1       = {128{1'b0}};
`endif
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = rand_line();
        end
        model_mem[3] = 128'h0000000D_0000000C_0000000B_0000000A;
        for (int i = 0; i < DEPTH; i++) begin
            dut.mem_q[i]  <= model_mem[i];
            dut1.mem_q[i] <= model_mem[i];
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy",  128'(MemBusy),  128'(1'b0));
        chk("rst_ready", 128'(MemReady), 128'(1'b0));
        chk("rst_line",  MemLine, {128{1'b0}});
        rst = 1'b1;

        // Preloaded line 3 through address 0x34.
        read_txn("preload", 32'h0000_0034, 32'h0000_0034);
        // Address moves from line 1 to line 2 mid-flight; line 1 is expected.
        read_txn("addr_chg", 32'h0000_0010, 32'h0000_0020);

`ifdef DMEM_WRITE_EN
        write_txn("wr_wrap", 32'h1000_0020, {128{1'b1}}, 1'b0);
        read_txn("rd_wrap", 32'h0000_0020, 32'h0000_0020);
        write_txn("wr_both", 32'h0000_0040, rand_line(), 1'b1);
        read_txn("rd_both", 32'h0000_0040, 32'h0000_0040);
`endif

        // Random addresses, including upper bits that must wrap.
        for (int i = 0; i < 12; i++) begin
            read_txn("rand", $urandom, $urandom);
        end

        // Reset in the third WAIT cycle of a read.
        @(negedge clk);
        AMem    = 32'h0000_0050;
        MemRead = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy",  128'(MemBusy),  128'(1'b0));
        chk("abort_line",  MemLine, {128{1'b0}});
        chk("abort_ready", 128'(MemReady), 128'(1'b0));
        MemRead   = 1'b0;
        last_line = {128{1'b0}};
        pulses    = 0;
        repeat (4) begin
            @(negedge clk);
            if (MemReady) pulses++;
        end
        chk("abort_pulses", 128'(pulses), 128'(0));
        rst = 1'b1;
        read_txn("after_abort", 32'h0000_0050, 32'h0000_0050);

        // LATENCY=1 with MemRead held high: one pulse every three cycles.
        @(negedge clk);
        a1     = 32'h0000_0050;
        rd1    = 1'b1;
        prev   = 0;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ready1) begin
                pulses++;
                chk("lat1_gap", 128'(k - prev), (prev == 0) ? 128'(1) : 128'(3));
                chk("lat1_data", line1, model_mem[5]);
                chk("lat1_busy", 128'(busy1), 128'(1'b1));
                prev = k;
            end
        end
        chk("lat1_pulses", 128'(pulses), 128'(4));
        rd1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5, sets cycles from request acceptance to MemReady; legal range 1..15.
REQ-002 Parameter DEPTH_LINES, default 256, sets the number of 128-bit lines stored; must be a power of two.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-low.
REQ-005 Port AMem  input  32  byte address of the requested line.
REQ-006 Port MemRead  input  1  line-read request, a level held by the cache until MemReady.
REQ-007 Port MemWrite  input  1  line-write request, a level held until MemReady; present only with DMEM_WRITE_EN.
REQ-008 Port WriteLine  input  128  line data to store; present only with DMEM_WRITE_EN.
REQ-009 Port MemLine  output  128  read line; word k occupies bits [32k+31:32k].
REQ-010 Port MemReady  output  1  one-cycle completion pulse.
REQ-011 Port MemBusy  output  1  high whenever the state is not IDLE.

Function
REQ-012 The line index SHALL be AMem[log2(DEPTH_LINES)+3:4]; AMem[3:0] and the upper bits are ignored, so addresses wrap modulo DEPTH_LINES lines.
REQ-013 The FSM SHALL have four states: IDLE, WAIT, RESP and DONE.
REQ-014 IDLE SHALL accept a request on the edge where MemRead (or MemWrite) is sampled high, latching the index, the operation and (for writes) WriteLine.
REQ-015 On acceptance the FSM SHALL go to WAIT with a 4-bit counter loaded with LATENCY-1, or go straight to RESP if LATENCY=1.
REQ-016 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-017 MemReady SHALL be high for exactly the one cycle spent in RESP, i.e. the cycle starting LATENCY edges after the accepting edge.
REQ-018 For a read, MemLine SHALL become the stored line of the latched index on entry to RESP, and hold that value until the next read response.
REQ-019 For a write, the array SHALL be updated on the edge entering RESP, and MemLine SHALL be unchanged.
REQ-020 RESP SHALL always go to DONE; DONE SHALL ignore all requests for one cycle and then go to IDLE, giving the initiator time to drop its request.
REQ-021 Changes on AMem, MemRead, MemWrite or WriteLine after acceptance SHALL NOT affect the operation in flight.
REQ-022 If MemRead and MemWrite are both high in IDLE, the write SHALL be served and the read ignored.
REQ-023 A request still held high on leaving DONE SHALL be treated as a new request.

Reset
REQ-024 Assertion of rst (low) SHALL immediately force the state to IDLE, the counter to 0, MemReady to 0, MemBusy to 0 and MemLine to 0.
REQ-025 Reset during WAIT or RESP SHALL abort the operation with no MemReady pulse.
REQ-026 An aborted write SHALL leave the array unchanged unless the write edge has already occurred.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro DMEM_WRITE_EN defined, MemWrite and WriteLine SHALL exist and writes SHALL behave per REQ-014..REQ-022.
REQ-029 Without DMEM_WRITE_EN, those ports SHALL be absent and the block SHALL be read-only, with its array contents set only by simulation preload.

Verification
REQ-030 Preload line 3 = 0x0000000D_0000000C_0000000B_0000000A, LATENCY=5; hold MemRead=1 with AMem=0x34 -> MemBusy rises the next cycle, MemReady pulses once 5 edges after acceptance, and MemLine equals the preloaded value.
REQ-031 With DMEM_WRITE_EN: write 0xFFFF...FFFF to AMem=0x1000_0020, then read AMem=0x20 -> the read returns all ones, because of index wrap with DEPTH_LINES=256.
REQ-032 Assert MemRead and MemWrite together at AMem=0x40 -> only the write is performed, with a single MemReady pulse; a following read of 0x40 returns WriteLine.
REQ-033 Pull rst low in the 3rd WAIT cycle of a read -> MemReady never pulses, MemBusy=0 and MemLine=0 immediately, and a later read of the same line succeeds with full latency.
REQ-034 Keep MemRead high continuously with LATENCY=1 -> MemReady pulses every 3 cycles (RESP, DONE, IDLE-accept), with no double pulse.
REQ-035 Change AMem from 0x10 to 0x20 during WAIT -> the response returns line 1, not line 2.
